// File: rtl/frost_share_collector.sv
// Receive-side FROST DKG share collector: captures 4 dealer shares, range-checks them,
// then sums them mod ORDER. Optional FROST_COLLECT_CYCLES_EN adds a cycles[15:0] port.
module frost_share_collector #(
  parameter int unsigned               SCALAR_BITS    = 253,
  parameter logic [SCALAR_BITS-1:0]    ORDER          =
    253'h1000000000000000000000000000000014DEF9DEA2F79CD65812631A5CF5D3ED,
  parameter int unsigned               TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SCALAR_BITS-1:0] shares_in_0,
  input  logic [SCALAR_BITS-1:0] shares_in_1,
  input  logic [SCALAR_BITS-1:0] shares_in_2,
  input  logic [SCALAR_BITS-1:0] shares_in_3,
  input  logic                   shares_valid_0,
  input  logic                   shares_valid_1,
  input  logic                   shares_valid_2,
  input  logic                   shares_valid_3,
  output logic [SCALAR_BITS-1:0] secret_share,
  output logic                   done,
  output logic                   busy,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic [3:0]             rcvd_mask
`ifdef FROST_COLLECT_CYCLES_EN
  ,
  output logic [15:0]            cycles
`endif
);

  // Wide enough to hold TIMEOUT_CYCLES itself (reached on the edge after a late full mask).
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [2:0] {StIdle, StCollect, StSum, StDone, StErr} state_e;

  state_e                        state_q, state_d;
  logic [3:0][SCALAR_BITS-1:0]   share_q, share_d;
  logic [3:0]                    mask_q, mask_d;
  logic [1:0]                    code_q, code_d;
  logic [TmoW-1:0]               tmo_q, tmo_d;
  logic [SCALAR_BITS-1:0]        acc_q, acc_d;
  logic [1:0]                    idx_q, idx_d;
  logic [SCALAR_BITS-1:0]        secret_q, secret_d;

  logic [3:0][SCALAR_BITS-1:0]   share_in;
  logic [3:0]                    valid_in;
  logic [3:0]                    cap;
  logic [3:0]                    bad;
  logic [SCALAR_BITS:0]          add_sum;
  logic [SCALAR_BITS-1:0]        mod_sum;

  always_comb begin
    share_in = {shares_in_3, shares_in_2, shares_in_1, shares_in_0};
    valid_in = {shares_valid_3, shares_valid_2, shares_valid_1, shares_valid_0};
    // Only lanes not yet received are eligible; first value wins.
    for (int j = 0; j < 4; j++) begin
      cap[j] = valid_in[j] & ~mask_q[j] & (share_in[j] < ORDER);
      bad[j] = valid_in[j] & ~mask_q[j] & ~(share_in[j] < ORDER);
    end
  end

  // Both operands are < ORDER, so a single conditional subtract reduces the sum.
  always_comb begin
    add_sum = {1'b0, acc_q} + {1'b0, share_q[idx_q]};
    if (add_sum >= {1'b0, ORDER}) begin
      mod_sum = SCALAR_BITS'(add_sum - {1'b0, ORDER});
    end else begin
      mod_sum = add_sum[SCALAR_BITS-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    share_d  = share_q;
    mask_d   = mask_q;
    code_d   = code_q;
    tmo_d    = tmo_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    secret_d = secret_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d  = StCollect;
          mask_d   = 4'h0;
          code_d   = 2'd0;
          tmo_d    = '0;
          secret_d = '0;
        end
      end
      StCollect: begin
        tmo_d = tmo_q + TmoW'(1);
        for (int j = 0; j < 4; j++) begin
          if (cap[j]) share_d[j] = share_in[j];
        end
        mask_d = mask_q | cap;
        if (mask_q == 4'hF) begin
          state_d = StSum;
          acc_d   = '0;
          idx_d   = 2'd0;
        end else if (|bad) begin
          state_d = StErr;
          code_d  = 2'd2;
        end else if (mask_d != 4'hF && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StErr;
          code_d  = 2'd1;
        end
      end
      StSum: begin
        acc_d = mod_sum;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          secret_d = mod_sum;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      share_q  <= '0;
      mask_q   <= 4'h0;
      code_q   <= 2'd0;
      tmo_q    <= '0;
      acc_q    <= '0;
      idx_q    <= 2'd0;
      secret_q <= '0;
    end else begin
      state_q  <= state_d;
      share_q  <= share_d;
      mask_q   <= mask_d;
      code_q   <= code_d;
      tmo_q    <= tmo_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      secret_q <= secret_d;
    end
  end

  assign done         = (state_q == StDone);
  assign busy         = (state_q == StCollect) || (state_q == StSum);
  assign error        = (state_q == StErr);
  assign error_code   = code_q;
  assign rcvd_mask    = mask_q;
  assign secret_share = secret_q;

`ifdef FROST_COLLECT_CYCLES_EN
  logic [15:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (busy && cycles_q != 16'hFFFF) begin
      cycles_d = cycles_q + 16'd1;
    end
    if ((state_q == StIdle || state_q == StDone || state_q == StErr) && start) begin
      cycles_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= 16'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule
